// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and helpers for the fetch PC generator
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_RAS,
        NPC_REDIR,
        NPC_TRAP
    } npc_sel_e;

    // Mask that clears the low log2(inc) address bits; callers truncate to XLEN.
    function automatic logic [63:0] align_mask(input int unsigned inc);
        return ~(64'(inc) - 64'd1);
    endfunction

endpackage

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address stack, oldest entry overwritten when full
module ras_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem [RAS_DEPTH];
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   top_idx;
    logic [PW-1:0]   wr_idx;
    logic [CW-1:0]   count;
    logic            do_pop;

    assign top_idx = ptr - PW'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CW'(RAS_DEPTH));
    assign do_pop  = pop && !empty;

    // Push together with a successful pop replaces the top in place.
    assign wr_idx  = do_pop ? top_idx : ptr;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push && do_pop) begin
            ptr   <= ptr;
            count <= count;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + CW'(1);
            end
        end else if (do_pop) begin
            ptr   <= top_idx;
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && push) begin
            mem[wr_idx] <= data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// rtl/pc_gen.sv - fetch PC generator: trap/redirect/stall/RAS/sequential next-PC select
module pc_gen
    import pc_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_VEC = '0,
    parameter int unsigned INC       = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_target,
    input  logic            i_ras_push,
    input  logic            i_ras_pop,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_valid,
    output logic            o_misaligned,
    output logic            o_ras_empty,
    output logic            o_ras_full
);

    localparam logic [XLEN-1:0] MASK = XLEN'(align_mask(INC));

    npc_sel_e        sel;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    logic            ras_flush;

    assign o_pc_plus4 = o_pc + XLEN'(INC);

    always_comb begin
        sel = NPC_SEQ;
        if (i_trap) begin
            sel = NPC_TRAP;
        end else if (i_redirect) begin
            sel = NPC_REDIR;
        end else if (i_stall) begin
            sel = NPC_HOLD;
        end else if (i_ras_pop && !o_ras_empty) begin
            sel = NPC_RAS;
        end
    end

    // Stack only moves on cycles that actually advance sequentially or via RAS.
    assign ras_push  = i_ras_push && ((sel == NPC_SEQ) || (sel == NPC_RAS));
    assign ras_pop   = (sel == NPC_RAS);
    assign ras_flush = (sel == NPC_TRAP);

    always_comb begin
        pc_next = o_pc_plus4;
        case (sel)
            NPC_TRAP:  pc_next = i_trap_vec & MASK;
            NPC_REDIR: pc_next = i_redirect_target & MASK;
            NPC_HOLD:  pc_next = o_pc;
            NPC_RAS:   pc_next = ras_top;
            default:   pc_next = o_pc_plus4;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_pc         <= RESET_VEC;
            o_valid      <= 1'b0;
            o_misaligned <= 1'b0;
        end else begin
            o_pc         <= pc_next;
            o_valid      <= 1'b1;
            o_misaligned <= (sel == NPC_REDIR) && (|(i_redirect_target & ~MASK));
        end
    end

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (i_clk),
        .rst   (i_rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .flush (ras_flush),
        .data  (o_pc_plus4),
        .top   (ras_top),
        .empty (o_ras_empty),
        .full  (o_ras_full)
    );

endmodule

// File: tb/tb_pc_gen.sv
// tb/tb_pc_gen.sv - self-checking bench for pc_gen: vector table, corner sequences, random vs model
module tb_pc_gen;

    localparam logic [31:0] RV = 32'h100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0, trap = 1'b0, redirect = 1'b0, ras_push = 1'b0, ras_pop = 1'b0;
    logic [31:0] trap_vec = '0, redirect_target = '0;
    logic [31:0] pc, pc_plus4;
    logic        valid, misaligned, ras_empty, ras_full;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .XLEN      (32),
        .RESET_VEC (RV),
        .INC       (4),
        .RAS_DEPTH (4)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_trap            (trap),
        .i_trap_vec        (trap_vec),
        .i_redirect        (redirect),
        .i_redirect_target (redirect_target),
        .i_ras_push        (ras_push),
        .i_ras_pop         (ras_pop),
        .o_pc              (pc),
        .o_pc_plus4        (pc_plus4),
        .o_valid           (valid),
        .o_misaligned      (misaligned),
        .o_ras_empty       (ras_empty),
        .o_ras_full        (ras_full)
    );

    typedef struct {
        logic        stall, trap;
        logic [31:0] tv;
        logic        redir;
        logic [31:0] rt;
        logic        push, pop;
        logic [31:0] pc;
        logic        mis, empty, full;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic s, logic t, logic [31:0] tv, logic r, logic [31:0] rt,
                                logic pu, logic po, logic [31:0] epc, logic mis, logic em, logic fu);
        vec_t v;
        v.stall = s; v.trap = t; v.tv = tv; v.redir = r; v.rt = rt;
        v.push = pu; v.pop = po; v.pc = epc; v.mis = mis; v.empty = em; v.full = fu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic s, input logic t, input logic [31:0] tv, input logic r,
                        input logic [31:0] rt, input logic pu, input logic po);
        stall = s; trap = t; trap_vec = tv; redirect = r; redirect_target = rt;
        ras_push = pu; ras_pop = po;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
    endtask

    // Reference model: PC as a number, RAS as a bounded list of return addresses.
    logic [31:0] m_pc;
    logic        m_valid, m_mis;
    logic [31:0] m_ras[$];

    task automatic model_step(input logic r, input logic s, input logic t, input logic [31:0] tv,
                              input logic rd, input logic [31:0] rt, input logic pu, input logic po);
        logic [31:0] ret;
        logic [31:0] npc;
        if (r) begin
            m_pc = RV; m_valid = 0; m_mis = 0; m_ras.delete();
            return;
        end
        m_valid = 1;
        m_mis = 0;
        if (t) begin
            m_pc = {tv[31:2], 2'b00};
            m_ras.delete();
        end else if (rd) begin
            m_pc = {rt[31:2], 2'b00};
            m_mis = (rt[1:0] != 2'b00);
        end else if (!s) begin
            ret = m_pc + 32'd4;
            npc = ret;
            if (po && m_ras.size() > 0) npc = m_ras.pop_back();
            if (pu) begin
                m_ras.push_back(ret);
                if (m_ras.size() > 4) void'(m_ras.pop_front());
            end
            m_pc = npc;
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset for two cycles
        idle_cycles_reset(2);
        chk("reset_pc", pc, RV);
        chk("reset_valid", 32'(valid), 0);
        chk("reset_mis", 32'(misaligned), 0);
        chk("reset_empty", 32'(ras_empty), 1);
        chk("reset_full", 32'(ras_full), 0);

        //        stall trap tv            redir rt            push pop  pc            mis em fu
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 32'h104,      0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 32'h108,      0, 1, 0));
        tbl.push_back(mk(1, 0, 0,            1, 32'h2002,     0, 0, 32'h2000,     1, 1, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0,            0, 0, 32'h2000,     0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'h40,       0, 0, 32'h40,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 32'h44,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'h80,       0, 0, 32'h80,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 32'h84,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h84,       0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h44,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h48,       0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 32'h4C,       0, 0, 0));
        tbl.push_back(mk(1, 0, 0,            0, 0,            1, 1, 32'h4C,       0, 0, 0));
        tbl.push_back(mk(0, 1, 32'h80000003, 1, 32'h3,        0, 1, 32'h80000000, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'hFFFFFFFC, 0, 0, 32'hFFFFFFFC, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 0, 32'h0,        0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'h1FC,      0, 0, 32'h1FC,      0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 32'h200,      0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'h300,      0, 0, 32'h300,      0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 1, 32'h200,      0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h304,      0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            1, 0, 32'h308,      0, 0, 0));
        tbl.push_back(mk(0, 0, 0,            1, 32'h1001,     1, 1, 32'h1000,     1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0,            0, 1, 32'h308,      0, 1, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].stall, tbl[i].trap, tbl[i].tv, tbl[i].redir, tbl[i].rt, tbl[i].push, tbl[i].pop);
            chk($sformatf("vec%0d_pc", i), pc, tbl[i].pc);
            chk($sformatf("vec%0d_plus4", i), pc_plus4, tbl[i].pc + 32'd4);
            chk($sformatf("vec%0d_valid", i), 32'(valid), 1);
            chk($sformatf("vec%0d_mis", i), 32'(misaligned), 32'(tbl[i].mis));
            chk($sformatf("vec%0d_empty", i), 32'(ras_empty), 32'(tbl[i].empty));
            chk($sformatf("vec%0d_full", i), 32'(ras_full), 32'(tbl[i].full));
        end

        // Overflow: five pushes into a 4-deep stack drop the oldest return address
        idle_cycles_reset(1);
        step(0, 0, 0, 1, 32'h0, 0, 0);
        chk("ovf_start", pc, 32'h0);
        for (int i = 1; i <= 5; i++) begin
            step(0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("ovf_push%0d_pc", i), pc, 32'(4 * i));
            chk($sformatf("ovf_push%0d_full", i), 32'(ras_full), (i >= 4) ? 1 : 0);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 0, 0, 1);
            chk($sformatf("ovf_pop%0d_pc", i), pc, 32'h14 - 32'(4 * i));
            chk($sformatf("ovf_pop%0d_full", i), 32'(ras_full), 0);
        end
        chk("ovf_empty", 32'(ras_empty), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("ovf_pop_empty_seq", pc, 32'hC);

        // Reset mid-operation discards stack contents
        step(0, 0, 0, 0, 0, 1, 0);
        chk("mrst_pushed", 32'(ras_empty), 0);
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 1);
        rst = 1'b0;
        chk("mrst_pc", pc, RV);
        chk("mrst_valid", 32'(valid), 0);
        chk("mrst_empty", 32'(ras_empty), 1);
        step(0, 0, 0, 0, 0, 0, 1);
        chk("mrst_pop_seq", pc, RV + 32'd4);
        chk("mrst_valid_rise", 32'(valid), 1);

        // Randomized run against the reference model
        idle_cycles_reset(1);
        model_step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst, r_s, r_t, r_rd, r_pu, r_po;
            logic [31:0] r_tv, r_rt;
            r_rst = ($urandom_range(99) == 0);
            r_s   = ($urandom_range(5) == 0);
            r_t   = ($urandom_range(31) == 0);
            r_rd  = ($urandom_range(7) == 0);
            r_pu  = ($urandom_range(3) == 0);
            r_po  = ($urandom_range(3) == 0);
            r_tv  = $urandom();
            r_rt  = ($urandom_range(3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(15))) : $urandom();
            model_step(r_rst, r_s, r_t, r_tv, r_rd, r_rt, r_pu, r_po);
            rst = r_rst;
            step(r_s, r_t, r_tv, r_rd, r_rt, r_pu, r_po);
            rst = 1'b0;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_plus4", pc_plus4, m_pc + 32'd4);
            chk("rnd_valid", 32'(valid), 32'(m_valid));
            chk("rnd_mis", 32'(misaligned), 32'(m_mis));
            chk("rnd_empty", 32'(ras_empty), (m_ras.size() == 0) ? 1 : 0);
            chk("rnd_full", 32'(ras_full), (m_ras.size() == 4) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
